// File: rtl/snax_reshuffler_csr_sequencer.sv
// Autonomous CSR programming sequencer for the SNAX data reshuffler.
// Writes a job's config words and the start CSR, then polls status until idle.
module snax_reshuffler_csr_sequencer #(
    parameter int unsigned NumCfgRegs   = 8,
    parameter logic [31:0] CfgBaseAddr  = 32'd0,
    parameter logic [31:0] StartAddr    = 32'd8,
    parameter logic [31:0] StatusAddr   = 32'd9,
    parameter int unsigned BusyBit      = 0,
    parameter int unsigned PollGap      = 4,
    parameter int unsigned PollCntWidth = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       job_valid_i,
    output logic                       job_ready_o,
    input  logic [NumCfgRegs*32-1:0]   job_cfg_i,
    output logic [31:0]                io_csr_req_bits_data_o,
    output logic [31:0]                io_csr_req_bits_addr_o,
    output logic                       io_csr_req_bits_write_o,
    output logic                       io_csr_req_valid_o,
    input  logic                       io_csr_req_ready_i,
    input  logic                       io_csr_rsp_valid_i,
    output logic                       io_csr_rsp_ready_o,
    input  logic [31:0]                io_csr_rsp_bits_data_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [PollCntWidth-1:0]    poll_count_o
);

    localparam int unsigned IdxW = (NumCfgRegs > 1) ? $clog2(NumCfgRegs) : 1;
    localparam int unsigned GapW = (PollGap > 1) ? $clog2(PollGap) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumCfgRegs - 1);
    localparam logic [GapW-1:0] LastGap =
        GapW'((PollGap > 0) ? PollGap - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        WR_CFG,
        WR_START,
        POLL_REQ,
        POLL_RSP,
        POLL_WAIT,
        DONE
    } state_e;

    state_e                        state_q;
    logic [NumCfgRegs-1:0][31:0]   cfg_q;
    logic [IdxW-1:0]               idx_q;
    logic [IdxW-1:0]               idx_nxt;
    logic [GapW-1:0]               gap_q;
    logic                          rsp_busy;
    logic                          rsp_data_unused;

    assign idx_nxt  = idx_q + IdxW'(1);
    assign rsp_busy = io_csr_rsp_bits_data_i[BusyBit];
    // Only the busy flag matters; the rest of the status word is ignored.
    assign rsp_data_unused = ^io_csr_rsp_bits_data_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q                 <= IDLE;
            cfg_q                   <= '0;
            idx_q                   <= '0;
            gap_q                   <= '0;
            job_ready_o             <= 1'b1;
            io_csr_req_bits_data_o  <= '0;
            io_csr_req_bits_addr_o  <= '0;
            io_csr_req_bits_write_o <= 1'b0;
            io_csr_req_valid_o      <= 1'b0;
            io_csr_rsp_ready_o      <= 1'b0;
            busy_o                  <= 1'b0;
            done_o                  <= 1'b0;
            poll_count_o            <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (job_valid_i) begin
                        cfg_q                   <= job_cfg_i;
                        idx_q                   <= '0;
                        poll_count_o            <= '0;
                        job_ready_o             <= 1'b0;
                        busy_o                  <= 1'b1;
                        io_csr_req_valid_o      <= 1'b1;
                        io_csr_req_bits_write_o <= 1'b1;
                        io_csr_req_bits_addr_o  <= CfgBaseAddr;
                        io_csr_req_bits_data_o  <= job_cfg_i[31:0];
                        state_q                 <= WR_CFG;
                    end
                end
                WR_CFG: begin
                    if (io_csr_req_ready_i) begin
                        if (idx_q == LastIdx) begin
                            io_csr_req_bits_addr_o <= StartAddr;
                            io_csr_req_bits_data_o <= 32'h1;
                            state_q                <= WR_START;
                        end else begin
                            idx_q                  <= idx_nxt;
                            io_csr_req_bits_addr_o <= CfgBaseAddr + 32'(idx_nxt);
                            io_csr_req_bits_data_o <= cfg_q[idx_nxt];
                        end
                    end
                end
                WR_START: begin
                    if (io_csr_req_ready_i) begin
                        io_csr_req_bits_write_o <= 1'b0;
                        io_csr_req_bits_addr_o  <= StatusAddr;
                        io_csr_req_bits_data_o  <= '0;
                        state_q                 <= POLL_REQ;
                    end
                end
                POLL_REQ: begin
                    if (io_csr_req_ready_i) begin
                        if (poll_count_o != '1) begin
                            poll_count_o <= poll_count_o + 1'b1;
                        end
                        io_csr_req_valid_o     <= 1'b0;
                        io_csr_req_bits_addr_o <= '0;
                        io_csr_rsp_ready_o     <= 1'b1;
                        state_q                <= POLL_RSP;
                    end
                end
                POLL_RSP: begin
                    if (io_csr_rsp_valid_i) begin
                        io_csr_rsp_ready_o <= 1'b0;
                        if (!rsp_busy) begin
                            done_o  <= 1'b1;
                            state_q <= DONE;
                        end else if (PollGap == 0) begin
                            io_csr_req_valid_o     <= 1'b1;
                            io_csr_req_bits_addr_o <= StatusAddr;
                            state_q                <= POLL_REQ;
                        end else begin
                            gap_q   <= '0;
                            state_q <= POLL_WAIT;
                        end
                    end
                end
                POLL_WAIT: begin
                    if (gap_q == LastGap) begin
                        io_csr_req_valid_o     <= 1'b1;
                        io_csr_req_bits_addr_o <= StatusAddr;
                        state_q                <= POLL_REQ;
                    end else begin
                        gap_q <= gap_q + GapW'(1);
                    end
                end
                DONE: begin
                    done_o      <= 1'b0;
                    busy_o      <= 1'b0;
                    job_ready_o <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snax_reshuffler_csr_sequencer.sv
// Scoreboard bench: two sequencers (poll gap 4 and 0) share the job stimulus.
// Expected CSR traffic is queued on job acceptance and checked by a monitor.
module tb_snax_reshuffler_csr_sequencer;

    localparam int N = 8;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        write;
        int          cyc;
    } req_t;

    localparam logic [N*32-1:0] JOB_A = {
        32'hA000_0007, 32'hA000_0006, 32'hA000_0005, 32'hA000_0004,
        32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    localparam logic [N*32-1:0] JOB_B = {
        32'h0BAD_F00D, 32'h1234_5678, 32'hFFFF_0000, 32'h0000_FFFF,
        32'h5555_AAAA, 32'hAAAA_5555, 32'h8000_0001, 32'h7FFF_FFFE};
    localparam logic [N*32-1:0] JOB_C = {
        32'hC7C7_C7C7, 32'hC6C6_C6C6, 32'hC5C5_C5C5, 32'hC4C4_C4C4,
        32'hC3C3_C3C3, 32'hC2C2_C2C2, 32'hC1C1_C1C1, 32'hC0C0_C0C0};
    localparam logic [N*32-1:0] JOB_D = {
        32'hD000_0070, 32'hD000_0060, 32'hD000_0050, 32'hD000_0040,
        32'hD000_0030, 32'hD000_0020, 32'hD000_0010, 32'hD000_0000};
    localparam logic [N*32-1:0] JOB_E = {
        32'hE111_1117, 32'hE111_1116, 32'hE111_1115, 32'hE111_1114,
        32'hE111_1113, 32'hE111_1112, 32'hE111_1111, 32'hE111_1110};
    localparam logic [N*32-1:0] JOB_F = {
        32'hF0F0_0007, 32'hF0F0_0006, 32'hF0F0_0005, 32'hF0F0_0004,
        32'hF0F0_0003, 32'hF0F0_0002, 32'hF0F0_0001, 32'hF0F0_0000};
    localparam logic [N*32-1:0] JOB_G = {
        32'h9999_0007, 32'h9999_0006, 32'h9999_0005, 32'h9999_0004,
        32'h9999_0003, 32'h9999_0002, 32'h9999_0001, 32'h9999_0000};

    logic              clk = 1'b0;
    logic              rst_n;
    logic              job_valid [2];
    logic              job_ready [2];
    logic [N*32-1:0]   job_cfg   [2];
    logic [31:0]       req_data  [2];
    logic [31:0]       req_addr  [2];
    logic              req_write [2];
    logic              req_valid [2];
    logic              req_ready;
    logic              rsp_valid [2];
    logic              rsp_ready [2];
    logic [31:0]       rsp_data  [2];
    logic              busy      [2];
    logic              done      [2];
    logic [15:0]       poll_cnt  [2];

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   bp = 1'b0;
    req_t q0[$];
    req_t q1[$];
    int   pq0[$];
    int   pq1[$];
    int   fin_m     [2];
    int   last_done [2];
    int   n_done    [2];
    int   reads     [2];
    int   busy_n    [2];
    bit   gap_chk   [2];
    int   gap_m     [2];
    bit   held      [2];
    req_t held_v    [2];
    bit   after_done[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    snax_reshuffler_csr_sequencer #(.PollGap(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .job_valid_i(job_valid[0]), .job_ready_o(job_ready[0]),
        .job_cfg_i(job_cfg[0]),
        .io_csr_req_bits_data_o(req_data[0]),
        .io_csr_req_bits_addr_o(req_addr[0]),
        .io_csr_req_bits_write_o(req_write[0]),
        .io_csr_req_valid_o(req_valid[0]),
        .io_csr_req_ready_i(req_ready),
        .io_csr_rsp_valid_i(rsp_valid[0]),
        .io_csr_rsp_ready_o(rsp_ready[0]),
        .io_csr_rsp_bits_data_i(rsp_data[0]),
        .busy_o(busy[0]), .done_o(done[0]), .poll_count_o(poll_cnt[0]));

    snax_reshuffler_csr_sequencer #(.PollGap(0)) dut_gap0 (
        .clk_i(clk), .rst_ni(rst_n),
        .job_valid_i(job_valid[1]), .job_ready_o(job_ready[1]),
        .job_cfg_i(job_cfg[1]),
        .io_csr_req_bits_data_o(req_data[1]),
        .io_csr_req_bits_addr_o(req_addr[1]),
        .io_csr_req_bits_write_o(req_write[1]),
        .io_csr_req_valid_o(req_valid[1]),
        .io_csr_req_ready_i(req_ready),
        .io_csr_rsp_valid_i(rsp_valid[1]),
        .io_csr_rsp_ready_o(rsp_ready[1]),
        .io_csr_rsp_bits_data_i(rsp_data[1]),
        .busy_o(busy[1]), .done_o(done[1]), .poll_count_o(poll_cnt[1]));

    function automatic void chk(string nm, int d, logic [31:0] got,
                                logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %h, expected %h", nm, d, got, exp);
        end
    endfunction

    function automatic void fail_now(string nm, int d);
        n_cmp++;
        n_err++;
        $display("FAIL %s dut%0d at cycle %0d", nm, d, cyc);
    endfunction

    function automatic void push_req(int d, req_t r);
        if (d == 0) q0.push_back(r);
        else q1.push_back(r);
    endfunction

    function automatic bit pop_req(int d, output req_t r);
        r = '{32'h0, 32'h0, 1'b0, -1};
        if (d == 0) begin
            if (q0.size() == 0) return 1'b0;
            r = q0.pop_front();
        end else begin
            if (q1.size() == 0) return 1'b0;
            r = q1.pop_front();
        end
        return 1'b1;
    endfunction

    function automatic bit pop_poll(int d, output int p);
        p = 0;
        if (d == 0) begin
            if (pq0.size() == 0) return 1'b0;
            p = pq0.pop_front();
        end else begin
            if (pq1.size() == 0) return 1'b0;
            p = pq1.pop_front();
        end
        return 1'b1;
    endfunction

    // Monitor: pops expected traffic on every request handshake.
    always @(negedge clk) begin
        req_t e;
        int   p;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                held[d] = 1'b0;
                after_done[d] = 1'b0;
                gap_chk[d] = 1'b0;
                continue;
            end
            if (held[d]) begin
                chk("hold_valid", d, 32'(req_valid[d]), 32'h1);
                chk("hold_addr", d, req_addr[d], held_v[d].addr);
                chk("hold_data", d, req_data[d], held_v[d].data);
                chk("hold_write", d, 32'(req_write[d]), 32'(held_v[d].write));
                held[d] = 1'b0;
            end
            if (req_valid[d]) begin
                if (gap_chk[d]) begin
                    chk("poll_gap", d, cyc, gap_m[d] + (d == 0 ? 4 : 0));
                    gap_chk[d] = 1'b0;
                end
                if (req_ready) begin
                    if (!pop_req(d, e)) begin
                        fail_now("unexpected_req", d);
                    end else begin
                        chk("req_addr", d, req_addr[d], e.addr);
                        chk("req_data", d, req_data[d], e.data);
                        chk("req_write", d, 32'(req_write[d]), 32'(e.write));
                        if (e.cyc >= 0) chk("req_cycle", d, cyc, e.cyc);
                    end
                end else begin
                    held[d] = 1'b1;
                    held_v[d] = '{req_addr[d], req_data[d], req_write[d], -1};
                end
            end
            if (rsp_valid[d] && rsp_ready[d]) begin
                if (rsp_data[d][0]) begin
                    gap_chk[d] = 1'b1;
                    gap_m[d] = cyc + 1;
                end else begin
                    fin_m[d] = cyc + 1;
                end
            end
            if (after_done[d]) begin
                chk("done_width", d, 32'(done[d]), 32'h0);
                chk("ready_after_done", d, 32'(job_ready[d]), 32'h1);
                after_done[d] = 1'b0;
            end
            if (done[d]) begin
                n_done[d]++;
                last_done[d] = cyc;
                chk("done_cycle", d, cyc, fin_m[d]);
                chk("done_vs_ready", d, 32'(job_ready[d]), 32'h0);
                if (!pop_poll(d, p)) fail_now("unexpected_done", d);
                else chk("poll_count", d, 32'(poll_cnt[d]), p);
                after_done[d] = 1'b1;
            end
        end
    end

    // Status responder: busy for the first busy_n reads of each job.
    task automatic responder(int d);
        forever begin
            @(negedge clk);
            if (rst_n && req_valid[d] && req_ready && !req_write[d]) begin
                @(posedge clk);
                #2;
                rsp_valid[d] = 1'b1;
                rsp_data[d]  = (reads[d] < busy_n[d]) ? 32'h8000_0001
                                                      : 32'hFFFF_FFFE;
                reads[d]++;
                for (int t = 0; t < 20; t++) begin
                    @(negedge clk);
                    if (rsp_ready[d]) break;
                end
                @(posedge clk);
                #2;
                rsp_valid[d] = 1'b0;
                rsp_data[d]  = '0;
            end
        end
    endtask

    initial responder(0);
    initial responder(1);

    initial begin
        req_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            req_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic start_job(int d, logic [N*32-1:0] cfg, int nb,
                             bit hold, bit chk_after);
        bit ok = 1'b0;
        int n;
        @(posedge clk);
        #2;
        job_cfg[d]   = cfg;
        job_valid[d] = 1'b1;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (job_ready[d]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            fail_now("job_accept_timeout", d);
            job_valid[d] = 1'b0;
            return;
        end
        n = cyc + 1;
        if (chk_after) chk("accept_after_done", d, n, last_done[d] + 2);
        for (int k = 0; k < N; k++)
            push_req(d, '{32'(k), cfg[k*32 +: 32], 1'b1, bp ? -1 : n + k});
        push_req(d, '{32'd8, 32'h1, 1'b1, bp ? -1 : n + 8});
        for (int r = 0; r <= nb; r++)
            push_req(d, '{32'd9, 32'h0, 1'b0, (bp || r > 0) ? -1 : n + 9});
        if (d == 0) pq0.push_back(nb + 1);
        else pq1.push_back(nb + 1);
        reads[d]  = 0;
        busy_n[d] = nb;
        @(posedge clk);
        #2;
        if (!hold) job_valid[d] = 1'b0;
    endtask

    task automatic wait_done(int d, int target);
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (n_done[d] >= target) return;
        end
        fail_now("done_timeout", d);
    endtask

    task automatic check_reset(int d);
        chk("rst_req_valid", d, 32'(req_valid[d]), 32'h0);
        chk("rst_req_addr", d, req_addr[d], 32'h0);
        chk("rst_req_data", d, req_data[d], 32'h0);
        chk("rst_req_write", d, 32'(req_write[d]), 32'h0);
        chk("rst_rsp_ready", d, 32'(rsp_ready[d]), 32'h0);
        chk("rst_busy", d, 32'(busy[d]), 32'h0);
        chk("rst_done", d, 32'(done[d]), 32'h0);
        chk("rst_poll_count", d, 32'(poll_cnt[d]), 32'h0);
        chk("rst_job_ready", d, 32'(job_ready[d]), 32'h1);
    endtask

    initial begin
        bit hit = 1'b0;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            job_valid[d] = 1'b0;
            job_cfg[d]   = '0;
            rsp_valid[d] = 1'b0;
            rsp_data[d]  = '0;
            n_done[d]    = 0;
            last_done[d] = 0;
            fin_m[d]     = -1;
            reads[d]     = 0;
            busy_n[d]    = 0;
        end
        #12;
        check_reset(0);
        check_reset(1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Single job, status idle on first read.
        fork
            start_job(0, JOB_A, 0, 1'b0, 1'b0);
            start_job(1, JOB_A, 0, 1'b0, 1'b0);
        join
        wait_done(0, 1);
        wait_done(1, 1);

        // Busy for three reads.
        fork
            start_job(0, JOB_B, 3, 1'b0, 1'b0);
            start_job(1, JOB_B, 3, 1'b0, 1'b0);
        join
        wait_done(0, 2);
        wait_done(1, 2);

        // Busy for two reads.
        fork
            start_job(0, JOB_C, 2, 1'b0, 1'b0);
            start_job(1, JOB_C, 2, 1'b0, 1'b0);
        join
        wait_done(0, 3);
        wait_done(1, 3);

        // Random request backpressure.
        bp = 1'b1;
        fork
            start_job(0, JOB_B, 1, 1'b0, 1'b0);
            start_job(1, JOB_B, 1, 1'b0, 1'b0);
        join
        wait_done(0, 4);
        wait_done(1, 4);
        bp = 1'b0;
        repeat (2) @(posedge clk);

        // job_valid held with a new descriptor while a job runs.
        fork
            begin
                start_job(0, JOB_D, 1, 1'b1, 1'b0);
                start_job(0, JOB_E, 0, 1'b0, 1'b1);
            end
            begin
                start_job(1, JOB_D, 1, 1'b1, 1'b0);
                start_job(1, JOB_E, 0, 1'b0, 1'b1);
            end
        join
        wait_done(0, 6);
        wait_done(1, 6);

        // Reset in the middle of the config writes.
        fork
            start_job(0, JOB_F, 0, 1'b0, 1'b0);
            start_job(1, JOB_F, 0, 1'b0, 1'b0);
        join
        for (int t = 0; t < 20; t++) begin
            @(posedge clk);
            #1;
            if (req_valid[0] && req_addr[0] == 32'd3) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) fail_now("reach_word3_timeout", 0);
        rst_n = 1'b0;
        #1;
        check_reset(0);
        check_reset(1);
        q0.delete();
        q1.delete();
        pq0.delete();
        pq1.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 0, 32'(job_ready[0]), 32'h1);
        chk("post_rst_ready", 1, 32'(job_ready[1]), 32'h1);
        fork
            start_job(0, JOB_G, 0, 1'b0, 1'b0);
            start_job(1, JOB_G, 0, 1'b0, 1'b0);
        join
        wait_done(0, 7);
        wait_done(1, 7);

        repeat (5) @(negedge clk);
        chk("queue_empty", 0, q0.size(), 32'h0);
        chk("queue_empty", 1, q1.size(), 32'h0);
        chk("poll_queue_empty", 0, pq0.size(), 32'h0);
        chk("poll_queue_empty", 1, pq1.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/snax_reshuffler_csr_sequencer.md
# snax_reshuffler_csr_sequencer

Autonomous CSR programming sequencer for the SNAX data reshuffler. It accepts one job descriptor of configuration words and writes them to the reshuffler's simplified CSR request port. It then writes the start CSR, polls the status CSR until the busy bit clears, and reports completion. It sits between a job source (core-side queue or DMA-fed descriptor) and the CSR request/response port normally driven by the SNAX interface translator.

## Interface

- NumCfgRegs, 8: number of 32-bit configuration words per job
- CfgBaseAddr, 0: CSR address of config word 0; word k goes to CfgBaseAddr+k
- StartAddr, 8: CSR address of the start register (written with 32'h1)
- StatusAddr, 9: CSR address of the status register (read)
- BusyBit, 0: bit index of busy flag in status data
- PollGap, 4: idle cycles between a "busy" response and the next poll request (0 allowed)
- PollCntWidth, 16: width of poll counter
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- job_valid_i  in  1  job descriptor valid
- job_ready_o  out  1  sequencer accepts a job
- job_cfg_i  in  NumCfgRegs*32  config words, word k at bits [32k+31:32k]
- io_csr_req_bits_data_o  out  32  CSR write data
- io_csr_req_bits_addr_o  out  32  CSR address
- io_csr_req_bits_write_o  out  1  1 = write, 0 = read
- io_csr_req_valid_o  out  1  CSR request valid
- io_csr_req_ready_i  in  1  CSR request ready
- io_csr_rsp_valid_i  in  1  CSR read response valid
- io_csr_rsp_ready_o  out  1  CSR response ready
- io_csr_rsp_bits_data_i  in  32  CSR read data
- busy_o  out  1  job in progress (any state except IDLE)
- done_o  out  1  one-cycle pulse on job completion
- poll_count_o  out  PollCntWidth  number of status reads in the last/current job

## Operation

- States: IDLE, WR_CFG, WR_START, POLL_REQ, POLL_RSP, POLL_WAIT, DONE.
- IDLE: job_ready_o=1. On job_valid_i&&job_ready_o, the block latches job_cfg_i into an internal register, clears the word index and poll_count_o, and goes to WR_CFG.
- WR_CFG: drive valid=1, write=1, addr=CfgBaseAddr+idx, data=cfg[idx]. On handshake, idx++; after word NumCfgRegs-1 goes to WR_START.
- WR_START: write addr=StartAddr, data=32'h1. On handshake, go to POLL_REQ.
- POLL_REQ: read addr=StatusAddr, data=0. On handshake, poll_count_o++ (saturating at all-ones), go to POLL_RSP.
- POLL_RSP: rsp_ready_o=1. On rsp_valid_i: if data[BusyBit]=1, go to POLL_WAIT (or directly to POLL_REQ if PollGap=0). Otherwise go to DONE.
- POLL_WAIT: count PollGap cycles, then go to POLL_REQ.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Writes complete on request handshake; no response is expected for writes. rsp_ready_o=0 in all states except POLL_RSP.
- The job register is not sampled again until the next IDLE acceptance. Changes on job_cfg_i mid-job have no effect.

## Timing

- Reset (async assert, sync-to-clock deassert behaviour by flops): state=IDLE, all request outputs 0, rsp_ready_o=0, busy_o=0, done_o=0, poll_count_o=0, job_ready_o=1.
- Reset mid-job: the job is abandoned immediately. Any outstanding CSR request is dropped (valid falls asynchronously).
- Job accepted at edge N → first config request valid in cycle N+1.
- Back-to-back writes: with ready_i held high, one request per cycle. NumCfgRegs+1 writes occupy NumCfgRegs+1 cycles.
- Once valid is asserted, addr/data/write stay stable until the handshake. valid never drops without a handshake (except on reset).
- Status response accepted at edge M: if not busy, done_o is high in cycle M+1 and job_ready_o is high in cycle M+2. If busy, the next poll request becomes valid in cycle M+1+PollGap.
- Response and request are never outstanding simultaneously (one read in flight maximum).
- done_o and job_ready_o are never high in the same cycle.

## Test plan

- Single job, NumCfgRegs=8, ready_i always 1, first status read returns 0: 8 writes to addr 0..7 with the job words in cycles 1..8, start write (addr 8, data 1) in cycle 9, read of addr 9 in cycle 10, done_o pulse, poll_count_o=1.
- Status busy for 3 reads then idle, PollGap=4: exactly 4 reads issued, with 4 idle request cycles between each response and the next read; poll_count_o=4; exactly one done_o pulse.
- Random backpressure on io_csr_req_ready_i (50%): addr/data stable while stalled; write order and values match the job exactly; no dropped or duplicated requests.
- job_valid_i held high with a new descriptor during a job: job_ready_o=0 until after DONE. The second job is accepted only in IDLE and its writes use the second descriptor's words.
- rst_ni asserted during WR_CFG at word 3: all outputs return to reset values the same cycle. After release, job_ready_o=1 and a new job programs from word 0.
- PollGap=0 with busy for 2 reads: the read is reissued the cycle after each busy response; poll_count_o=3.
